// File: rtl/flex_counter_pkg.sv
// Shared types and defaults for the loadable down-counting timer.
// Imported by the interface and the counter itself.
package flex_counter_pkg;

  localparam int unsigned DEF_NUM_CNT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/flex_down_counter_if.sv
// Control and status bundle for flex_down_counter.
// The master drives the controls and the slave (the counter) drives the status.
interface flex_down_counter_if
  import flex_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = DEF_NUM_CNT_BITS
);

  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    start;
  logic                    stop;
  logic                    count_enable;
  logic                    auto_reload;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    expire;
  logic                    busy;
  logic                    done;

  modport master (
    output load,
    output load_val,
    output start,
    output stop,
    output count_enable,
    output auto_reload,
    input  count_out,
    input  expire,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  load_val,
    input  start,
    input  stop,
    input  count_enable,
    input  auto_reload,
    output count_out,
    output expire,
    output busy,
    output done
  );

endinterface

// File: rtl/flex_down_counter.sv
// Loadable down-counting timer with one-shot and periodic modes.
// It pulses expire when the count reaches zero and holds all of its outputs in registers.
module flex_down_counter
  import flex_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
  input logic              clk,
  input logic              rst,
  flex_down_counter_if.slave bus
);

  localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;
  localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
  logic                    expire_q, expire_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = 1'b0;

    if (bus.load) begin
      reload_d = bus.load_val;
      count_d  = bus.load_val;
      state_d  = LOADED;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Nothing to count until a value has been loaded.
        end
        LOADED: begin
          if (!bus.stop && bus.start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = LOADED;
          end else if (bus.count_enable) begin
            if (count_q > CntOne) begin
              count_d = count_q - CntOne;
            end else if (count_q == CntOne) begin
              count_d  = CntZero;
              expire_d = 1'b1;
              if (!bus.auto_reload) begin
                state_d = DONE;
              end
            end else if (bus.auto_reload) begin
              // Zero is the last step of a period, so reload here.
              count_d  = reload_q;
              expire_d = (reload_q == CntZero);
            end else begin
              // A one-shot run that starts at zero expires on its first enabled cycle.
              state_d  = DONE;
              expire_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (!bus.stop && bus.start) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= CntZero;
      reload_q <= CntZero;
      expire_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.expire    = expire_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_flex_down_counter.sv
// Directed bench for flex_down_counter: each scenario task drives stimulus and checks
// the outputs inline against hand-computed values.
module tb_flex_down_counter;

  logic tb_clk = 1'b0;
  logic rst    = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 tb_clk = ~tb_clk;

  flex_down_counter_if #(.NUM_CNT_BITS(4)) bus ();

  flex_down_counter #(.NUM_CNT_BITS(4)) dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.load         = 1'b0;
    bus.load_val     = 4'd0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.count_enable = 1'b0;
    bus.auto_reload  = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.load         = 1'($urandom_range(0, 1));
      bus.load_val     = 4'($urandom);
      bus.start        = 1'($urandom_range(0, 1));
      bus.stop         = 1'($urandom_range(0, 1));
      bus.count_enable = 1'($urandom_range(0, 1));
      bus.auto_reload  = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (bus.count_out !== 4'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d expected 0", bus.count_out);
    end
    checks++;
    if ({bus.expire, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got expire/busy/done=%b expected 000",
               {bus.expire, bus.busy, bus.done});
    end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_one_shot();
    logic [3:0] e_cnt;
    logic       e_exp;
    do_load(4'd5);
    checks++;
    if (bus.count_out !== 4'd5 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_loaded: got count=%0d busy=%b expected 5 0", bus.count_out, bus.busy);
    end
    do_start();
    checks++;
    if (bus.count_out !== 4'd5 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_start: got count=%0d busy=%b expected 5 1", bus.count_out, bus.busy);
    end
    bus.count_enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      e_cnt = (i <= 5) ? 4'(5 - i) : 4'd0;
      e_exp = (i == 5);
      checks++;
      if (bus.count_out !== e_cnt || bus.expire !== e_exp ||
          bus.busy !== (i < 5) || bus.done !== (i >= 5)) begin
        failures++;
        $display("FAIL oneshot_step%0d: got count=%0d expire=%b busy=%b done=%b expected %0d %b %b %b",
                 i, bus.count_out, bus.expire, bus.busy, bus.done, e_cnt, e_exp, i < 5, i >= 5);
      end
    end
    bus.count_enable = 1'b0;
    do_start();
    checks++;
    if (bus.count_out !== 4'd5 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_restart: got count=%0d busy=%b done=%b expected 5 1 0",
               bus.count_out, bus.busy, bus.done);
    end
  endtask

  task automatic test_periodic();
    logic [3:0] exp_cnt [10] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1};
    logic       exp_exp [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.count_enable = 1'b0;
    do_load(4'd3);
    bus.auto_reload = 1'b1;
    do_start();
    checks++;
    if (bus.count_out !== 4'd3) begin
      failures++;
      $display("FAIL periodic_start: got %0d expected 3", bus.count_out);
    end
    bus.count_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.count_out !== exp_cnt[i] || bus.expire !== exp_exp[i] || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL periodic_step%0d: got count=%0d expire=%b busy=%b expected %0d %b 1",
                 i, bus.count_out, bus.expire, bus.busy, exp_cnt[i], exp_exp[i]);
      end
    end
    bus.count_enable = 1'b0;
    bus.auto_reload  = 1'b0;
  endtask

  task automatic test_pause();
    do_load(4'd9);
    do_start();
    bus.count_enable = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.count_out !== 4'd6) begin
      failures++;
      $display("FAIL pause_pre: got %0d expected 6", bus.count_out);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.count_out !== 4'd6 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold%0d: got count=%0d busy=%b expected 6 0", i, bus.count_out, bus.busy);
      end
      tick();
    end
    do_start();
    checks++;
    if (bus.count_out !== 4'd6 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pause_resume: got count=%0d busy=%b expected 6 1", bus.count_out, bus.busy);
    end
    tick();
    checks++;
    if (bus.count_out !== 4'd5) begin
      failures++;
      $display("FAIL pause_dec: got %0d expected 5", bus.count_out);
    end
    bus.count_enable = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.count_out !== 4'd5) begin
      failures++;
      $display("FAIL gate_hold: got %0d expected 5", bus.count_out);
    end
    bus.count_enable = 1'b1;
    tick();
    checks++;
    if (bus.count_out !== 4'd4) begin
      failures++;
      $display("FAIL gate_dec: got %0d expected 4", bus.count_out);
    end
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.count_out !== 4'd4 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_beats_start: got count=%0d busy=%b expected 4 0", bus.count_out, bus.busy);
    end
    bus.count_enable = 1'b0;
  endtask

  task automatic test_zero_max();
    bus.auto_reload = 1'b0;
    do_load(4'd0);
    do_start();
    bus.count_enable = 1'b1;
    tick();
    checks++;
    if (bus.count_out !== 4'd0 || bus.expire !== 1'b1 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL zero_oneshot: got count=%0d expire=%b done=%b expected 0 1 1",
               bus.count_out, bus.expire, bus.done);
    end
    tick();
    checks++;
    if (bus.expire !== 1'b0 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL zero_single_pulse: got expire=%b done=%b expected 0 1", bus.expire, bus.done);
    end
    bus.count_enable = 1'b0;
    do_load(4'd15);
    do_start();
    bus.count_enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (bus.count_out !== ((i <= 15) ? 4'(15 - i) : 4'd0) || bus.expire !== (i == 15)) begin
        failures++;
        $display("FAIL max_step%0d: got count=%0d expire=%b expected %0d %b",
                 i, bus.count_out, bus.expire, (i <= 15) ? 15 - i : 0, i == 15);
      end
    end
    bus.count_enable = 1'b0;
    bus.auto_reload  = 1'b1;
    do_load(4'd0);
    do_start();
    bus.count_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.count_out !== 4'd0 || bus.expire !== 1'b1 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL zero_periodic%0d: got count=%0d expire=%b busy=%b expected 0 1 1",
                 i, bus.count_out, bus.expire, bus.busy);
      end
    end
    bus.count_enable = 1'b0;
    tick();
    checks++;
    if (bus.expire !== 1'b0) begin
      failures++;
      $display("FAIL zero_periodic_gate: got expire=%b expected 0", bus.expire);
    end
    bus.auto_reload = 1'b0;
  endtask

  task automatic test_priority();
    bus.load     = 1'b1;
    bus.load_val = 4'd7;
    bus.start    = 1'b1;
    tick();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.count_out !== 4'd7 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL load_beats_start: got count=%0d busy=%b expected 7 0", bus.count_out, bus.busy);
    end
    bus.count_enable = 1'b1;
    tick();
    checks++;
    if (bus.count_out !== 4'd7 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL loaded_idle_enable: got count=%0d busy=%b expected 7 0", bus.count_out, bus.busy);
    end
    bus.count_enable = 1'b0;
    do_load(4'd6);
    do_start();
    bus.count_enable = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.count_out !== 4'd4) begin
      failures++;
      $display("FAIL midrun_pre: got %0d expected 4", bus.count_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.count_out !== 4'd0 || {bus.busy, bus.done, bus.expire} !== 3'b000) begin
      failures++;
      $display("FAIL midrun_reset: got count=%0d busy/done/expire=%b expected 0 000",
               bus.count_out, {bus.busy, bus.done, bus.expire});
    end
    bus.start = 1'b1;
    repeat (2) tick();
    bus.start = 1'b0;
    checks++;
    if (bus.count_out !== 4'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_start: got count=%0d busy=%b expected 0 0", bus.count_out, bus.busy);
    end
    bus.count_enable = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause();
    test_zero_max();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
